// File: rtl/calc_sequencer_if.sv
// Command and result stream bundle for calc_sequencer.
// The master drives commands and accepts results; the slave is the sequencer.
interface calc_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_data;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data;
  logic [1:0]  res_addr;

  modport master (
    output cmd_valid, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_addr
  );

  modport slave (
    input  cmd_valid, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_addr
  );
endinterface

// File: rtl/calc_sequencer.sv
// Sequences buffered instructions onto a negedge-writing calculator and reads back each result.
// Optional CALC_SEQ_STATS_EN adds an issue counter and a sticky command-overflow flag.
module calc_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_sequencer_if.slave  bus,
  output logic [1:0]       o_calc_rd_addr,
  output logic [3:0]       o_calc_immediate,
  output logic [1:0]       o_calc_we_addr,
  output logic [2:0]       o_calc_control,
  input  logic [3:0]       i_calc_rd_data
`ifdef CALC_SEQ_STATS_EN
  ,
  output logic [7:0]       o_issued_cnt,
  output logic             o_overflow_seen
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_READBACK = 2'd2,
    ST_RESULT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [10:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_res_valid;
  logic [3:0]       r_res_data;
  logic [1:0]       r_res_addr;
  logic [1:0]       r_calc_rd_addr;
  logic [3:0]       r_calc_immediate;
  logic [1:0]       r_calc_we_addr;
  logic [2:0]       r_calc_control;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [10:0]      w_head;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_push  = bus.cmd_valid && !w_full;
  // Every pop is an ISSUE entry: from IDLE, or from RESULT once the result is taken.
  assign w_pop   = !w_empty && ((r_state == ST_IDLE) ||
                                ((r_state == ST_RESULT) && bus.res_ready));
  assign w_head  = r_mem[r_rd_ptr];

  assign bus.cmd_ready    = !w_full;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_addr     = r_res_addr;
  assign o_calc_rd_addr   = r_calc_rd_addr;
  assign o_calc_immediate = r_calc_immediate;
  assign o_calc_we_addr   = r_calc_we_addr;
  assign o_calc_control   = r_calc_control;

  // FIFO storage array, written on push (data needs no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.cmd_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM; outside ISSUE the pins always carry R <= R | 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_res_valid      <= 1'b0;
      r_res_data       <= 4'h0;
      r_res_addr       <= 2'd0;
      r_calc_rd_addr   <= 2'd0;
      r_calc_immediate <= 4'h0;
      r_calc_we_addr   <= 2'd0;
      r_calc_control   <= 3'b001;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_calc_control   <= w_head[10:8];
            r_calc_we_addr   <= w_head[7:6];
            r_calc_rd_addr   <= w_head[5:4];
            r_calc_immediate <= w_head[3:0];
            r_state          <= ST_ISSUE;
          end else begin
            r_calc_control   <= 3'b001;
            r_calc_we_addr   <= 2'd0;
            r_calc_rd_addr   <= 2'd0;
            r_calc_immediate <= 4'h0;
            r_state          <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_calc_control   <= 3'b001;
          r_calc_rd_addr   <= r_calc_we_addr;
          r_calc_immediate <= 4'h0;
          r_state          <= ST_READBACK;
        end
        ST_READBACK: begin
          r_res_data  <= i_calc_rd_data;
          r_res_addr  <= r_calc_we_addr;
          r_res_valid <= 1'b1;
          r_state     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_calc_control   <= w_head[10:8];
              r_calc_we_addr   <= w_head[7:6];
              r_calc_rd_addr   <= w_head[5:4];
              r_calc_immediate <= w_head[3:0];
              r_state          <= ST_ISSUE;
            end else begin
              r_calc_control   <= 3'b001;
              r_calc_we_addr   <= 2'd0;
              r_calc_rd_addr   <= 2'd0;
              r_calc_immediate <= 4'h0;
              r_state          <= ST_IDLE;
            end
          end else begin
            r_state <= ST_RESULT;
          end
        end
        default: begin
          r_res_valid      <= 1'b0;
          r_calc_control   <= 3'b001;
          r_calc_we_addr   <= 2'd0;
          r_calc_rd_addr   <= 2'd0;
          r_calc_immediate <= 4'h0;
          r_state          <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CALC_SEQ_STATS_EN
  logic [7:0] r_issued_cnt;
  logic       r_overflow_seen;

  assign o_issued_cnt    = r_issued_cnt;
  assign o_overflow_seen = r_overflow_seen;

  // Issue counter (wraps) and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued_cnt    <= 8'd0;
      r_overflow_seen <= 1'b0;
    end else begin
      if (w_pop) begin
        r_issued_cnt <= r_issued_cnt + 8'd1;
      end
      if (bus.cmd_valid && w_full) begin
        r_overflow_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural 4-register calculator.
// Build with CALC_SEQ_STATS_EN defined to also exercise the statistics ports.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] calc_rd_addr;
  logic [3:0] calc_immediate;
  logic [1:0] calc_we_addr;
  logic [2:0] calc_control;
  logic [3:0] calc_rd_data;
`ifdef CALC_SEQ_STATS_EN
  logic [7:0] issued_cnt;
  logic       overflow_seen;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  calc_sequencer_if bus_if ();

  calc_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus_if),
    .o_calc_rd_addr   (calc_rd_addr),
    .o_calc_immediate (calc_immediate),
    .o_calc_we_addr   (calc_we_addr),
    .o_calc_control   (calc_control),
    .i_calc_rd_data   (calc_rd_data)
`ifdef CALC_SEQ_STATS_EN
    ,
    .o_issued_cnt     (issued_cnt),
    .o_overflow_seen  (overflow_seen)
`endif
  );

  always #5 clk = ~clk;

  // Calculator model: combinational read, ALU result written on every negedge
  logic [3:0] cregs [4] = '{default: 4'h0};
  assign calc_rd_data = cregs[calc_rd_addr];

  function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {3'b000, ($signed(a) < $signed(b))};
      default: return 4'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    cregs[calc_we_addr] <= alu(calc_control, cregs[calc_rd_addr], calc_immediate);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [10:0] pins();
    return {calc_control, calc_we_addr, calc_rd_addr, calc_immediate};
  endfunction

  task automatic push_cmd(input logic [10:0] d);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_data  = d;
    for (int i = 0; i < 50 && !bus_if.cmd_ready; i++) tick();
    check_val("push_ready", 32'(bus_if.cmd_ready), 32'd1);
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [10:0] d, input logic [3:0] exp_data, input logic [1:0] exp_addr);
    push_cmd(d);
    for (int i = 0; i < 20 && !bus_if.res_valid; i++) tick();
    check_val({tag, "_valid"}, 32'(bus_if.res_valid), 32'd1);
    check_val({tag, "_data"}, 32'(bus_if.res_data), 32'(exp_data));
    check_val({tag, "_addr"}, 32'(bus_if.res_addr), 32'(exp_addr));
    bus_if.res_ready = 1'b1;
    tick();
    bus_if.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [10:0] bp_cmd  [6];
  logic [3:0]  bp_data [6];
  logic [1:0]  bp_addr [6];
  int          got;
  logic        c6_acc;

  initial begin
    rst_n            = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_data  = 11'h000;
    bus_if.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check_val("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    check_val("rst_res_data", 32'(bus_if.res_data), 32'd0);
    check_val("rst_res_addr", 32'(bus_if.res_addr), 32'd0);
    check_val("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_val("rst_pins", 32'(pins()), 32'(11'b001_00_00_0000));

    // Latency: accept at N, ISSUE N+1, READBACK N+2, result N+3
    push_cmd(11'b010_01_00_0101);
    check_val("lat_n0_valid", 32'(bus_if.res_valid), 32'd0);
    tick();
    check_val("lat_issue_pins", 32'(pins()), 32'(11'b010_01_00_0101));
    check_val("lat_n1_valid", 32'(bus_if.res_valid), 32'd0);
    tick();
    check_val("lat_rdbk_pins", 32'(pins()), 32'(11'b001_01_01_0000));
    check_val("lat_n2_valid", 32'(bus_if.res_valid), 32'd0);
    tick();
    check_val("lat_n3_valid", 32'(bus_if.res_valid), 32'd1);
    check_val("lat_data", 32'(bus_if.res_data), 32'h5);
    check_val("lat_addr", 32'(bus_if.res_addr), 32'd1);
    bus_if.res_ready = 1'b1;
    tick();
    bus_if.res_ready = 1'b0;
    check_val("lat_drop_valid", 32'(bus_if.res_valid), 32'd0);

    do_op("sub", 11'b110_10_01_0111, 4'hE, 2'd2);
    do_op("slt", 11'b111_11_10_0001, 4'h1, 2'd3);

    // Back-pressure: r0=r1+1, r1=r0-2, r2=r2&3, r3=r1|8, r0=r3<1, r1=r0+15
    bp_cmd  = '{11'b010_00_01_0001, 11'b110_01_00_0010, 11'b000_10_10_0011,
                11'b001_11_01_1000, 11'b111_00_11_0001, 11'b010_01_00_1111};
    bp_data = '{4'h6, 4'h4, 4'h2, 4'hC, 4'h1, 4'h0};
    bp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) push_cmd(bp_cmd[i]);
    check_val("bp_ready_3", 32'(bus_if.cmd_ready), 32'd1);
    push_cmd(bp_cmd[4]);
    check_val("bp_ready_full", 32'(bus_if.cmd_ready), 32'd0);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_data  = bp_cmd[5];
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bp_hold_ready", 32'(bus_if.cmd_ready), 32'd0);
      check_val("bp_hold_valid", 32'(bus_if.res_valid), 32'd1);
      check_val("bp_hold_data", 32'(bus_if.res_data), 32'h6);
      check_val("bp_hold_addr", 32'(bus_if.res_addr), 32'd0);
    end
    bus_if.res_ready = 1'b1;
    got    = 0;
    c6_acc = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (bus_if.res_valid) begin
        check_val("bp_data", 32'(bus_if.res_data), 32'(bp_data[got]));
        check_val("bp_addr", 32'(bus_if.res_addr), 32'(bp_addr[got]));
        got++;
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) c6_acc = 1'b1;
      tick();
      if (c6_acc) bus_if.cmd_valid = 1'b0;
    end
    bus_if.res_ready = 1'b0;
    bus_if.cmd_valid = 1'b0;
    check_val("bp_count", 32'(got), 32'd6);

    // Idle: pins must stay NOP(R=0)
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("idle_pins", 32'(pins()), 32'(11'b001_00_00_0000));
    end
    do_op("rb_r0", 11'b001_00_00_0000, 4'h1, 2'd0);
    do_op("rb_r1", 11'b001_01_01_0000, 4'h0, 2'd1);
    do_op("rb_r2", 11'b001_10_10_0000, 4'h2, 2'd2);
    do_op("rb_r3", 11'b001_11_11_0000, 4'hC, 2'd3);

    // Reset mid-ISSUE must suppress the write to r1
    do_op("set_r1", 11'b010_01_10_0011, 4'h5, 2'd1);
    push_cmd(11'b010_01_01_0011);
    tick();
    check_val("pre_rst_pins", 32'(pins()), 32'(11'b010_01_01_0011));
    rst_n = 1'b0;
    #1;
    check_val("in_rst_pins", 32'(pins()), 32'(11'b001_00_00_0000));
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("post_rst_valid", 32'(bus_if.res_valid), 32'd0);
    end
    check_val("post_rst_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_val("post_rst_data", 32'(bus_if.res_data), 32'd0);
    check_val("post_rst_addr", 32'(bus_if.res_addr), 32'd0);
    check_val("post_rst_pins", 32'(pins()), 32'(11'b001_00_00_0000));
`ifdef CALC_SEQ_STATS_EN
    check_val("st_cnt_rst", 32'(issued_cnt), 32'd0);
    check_val("st_ovf_rst", 32'(overflow_seen), 32'd0);
`endif
    do_op("rb_r1_kept", 11'b001_01_01_0000, 4'h5, 2'd1);

`ifdef CALC_SEQ_STATS_EN
    do_op("st_rb0", 11'b001_00_00_0000, 4'h1, 2'd0);
    do_op("st_rb2", 11'b001_10_10_0000, 4'h2, 2'd2);
    check_val("st_cnt3", 32'(issued_cnt), 32'd3);
    for (int i = 0; i < 5; i++) push_cmd(11'b001_00_00_0000);
    check_val("st_ovf_before", 32'(overflow_seen), 32'd0);
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    check_val("st_ovf_set", 32'(overflow_seen), 32'd1);
    bus_if.res_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    bus_if.res_ready = 1'b0;
    check_val("st_ovf_sticky", 32'(overflow_seen), 32'd1);
    check_val("st_cnt8", 32'(issued_cnt), 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
